// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped UART: DATA/STATUS/CTRL/divisor registers, TX and RX FIFOs,
// 16x-oversampled receiver with framing/overrun flags and a maskable interrupt.
module mmio_uart_ctrl #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 19200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_mmio,
  input  logic       rd,
  input  logic       wr,
  input  logic [2:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / (BAUD * 16) - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic acc_rd, acc_wr, acc_rd_q, acc_wr_q, rd_data_q;
  logic wr_pulse, rd_fall, wr_data, wr_stat;
  logic [2:0] ctrl;
  logic [15:0] div, baud_cnt;
  logic tick;
  logic tx_ovf, fe, rx_ovr;

  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp;
  logic tx_empty, tx_full, tx_push, tx_pop, tx_ovf_set;
  logic [7:0] tx_head, tx_shift;
  logic [1:0] tx_state;
  logic [3:0] tx_tcnt;
  logic [2:0] tx_bit;

  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wp, rx_rp;
  logic rx_empty, rx_full, rx_push, rx_pop, rx_push_req, rx_ovr_set, fe_set, stop_sample;
  logic [7:0] rx_head, rx_shift;
  logic [1:0] rx_state;
  logic [3:0] rx_tcnt;
  logic [2:0] rx_bit;
  logic rx_ff1, rx_s;

  assign acc_rd   = rd & s_mmio;
  assign acc_wr   = wr & s_mmio;
  assign wr_pulse = acc_wr & ~acc_wr_q;
  assign rd_fall  = acc_rd_q & ~acc_rd;
  assign wr_data  = wr_pulse && (addr == 3'd0);
  assign wr_stat  = wr_pulse && (addr == 3'd1);

  // rd_data_q remembers whether the read that is ending actually saw a byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_rd_q  <= 1'b0;
      acc_wr_q  <= 1'b0;
      rd_data_q <= 1'b0;
    end else begin
      acc_rd_q <= acc_rd;
      acc_wr_q <= acc_wr;
      if (acc_rd) rd_data_q <= (addr == 3'd0) && !rx_empty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl <= 3'd0;
      div  <= DIV_RST;
    end else if (wr_pulse) begin
      case (addr)
        3'd2: ctrl <= data_in[2:0];
        3'd3: div[7:0] <= data_in;
        3'd4: div[15:8] <= data_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      fe     <= 1'b0;
      rx_ovr <= 1'b0;
    end else begin
      tx_ovf <= tx_ovf_set | (tx_ovf & ~(wr_stat & data_in[7]));
      fe     <= fe_set     | (fe     & ~(wr_stat & data_in[6]));
      rx_ovr <= rx_ovr_set | (rx_ovr & ~(wr_stat & data_in[5]));
    end
  end

  assign tick = (baud_cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) baud_cnt <= DIV_RST;
    else     baud_cnt <= tick ? div : baud_cnt - 16'd1;
  end

  // A pop while full frees the slot the simultaneous push needs
  assign tx_empty   = (tx_wp == tx_rp);
  assign tx_full    = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_head    = tx_mem[tx_rp[AW-1:0]];
  assign tx_pop     = !tx_empty && ((tx_state == S_IDLE) ||
                      ((tx_state == S_STOP) && tick && (tx_tcnt == 4'd15)));
  assign tx_push    = wr_data && (!tx_full || tx_pop);
  assign tx_ovf_set = wr_data && tx_full && !tx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= data_in;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  // STOP can chain straight into the next START so frames run back to back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx       <= 1'b1;
      tx_tcnt  <= 4'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
    end else begin
      case (tx_state)
        S_IDLE: if (tx_pop) begin
          tx_shift <= tx_head;
          tx       <= 1'b0;
          tx_tcnt  <= 4'd0;
          tx_state <= S_START;
        end
        S_START: if (tick) begin
          tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            tx_state <= S_DATA;
            tx       <= tx_shift[0];
            tx_bit   <= 3'd0;
          end
        end
        S_DATA: if (tick) begin
          tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              tx       <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
            end
          end
        end
        default: if (tick) begin
          tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            if (tx_pop) begin
              tx_shift <= tx_head;
              tx       <= 1'b0;
              tx_state <= S_START;
            end else begin
              tx_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign rx_empty    = (rx_wp == rx_rp);
  assign rx_full     = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_head     = rx_mem[rx_rp[AW-1:0]];
  assign stop_sample = (rx_state == S_STOP) && tick && (rx_tcnt == 4'd15);
  assign rx_push_req = stop_sample && rx_s;
  assign fe_set      = stop_sample && !rx_s;
  assign rx_pop      = rd_fall && rd_data_q && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign rx_ovr_set  = rx_push_req && rx_full && !rx_pop;

  // START is checked at its 8th tick; later samples fall 16 ticks apart, mid-bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ff1   <= 1'b1;
      rx_s     <= 1'b1;
      rx_state <= S_IDLE;
      rx_tcnt  <= 4'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_ff1 <= rx;
      rx_s   <= rx_ff1;
      case (rx_state)
        S_IDLE: if (!rx_s) begin
          rx_state <= S_START;
          rx_tcnt  <= 4'd0;
        end
        S_START: if (tick) begin
          if (rx_tcnt == 4'd7) begin
            rx_tcnt  <= 4'd0;
            rx_bit   <= 3'd0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_tcnt <= rx_tcnt + 4'd1;
          end
        end
        S_DATA: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end
        end
        default: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) rx_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty) |
                    (ctrl[2] & (fe | rx_ovr | tx_ovf));
  end

  always_comb begin
    data_out = 8'd0;
    if (acc_rd) begin
      case (addr)
        3'd0: data_out = rx_empty ? 8'd0 : rx_head;
        3'd1: data_out = {tx_ovf, fe, rx_ovr, 1'b0, tx_full, tx_empty, rx_full, rx_empty};
        3'd2: data_out = {5'd0, ctrl};
        3'd3: data_out = div[7:0];
        3'd4: data_out = div[15:8];
        default: data_out = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl: register readback, TX framing, loopback,
// FIFO overflow/overrun, framing and glitch rejection, interrupt and async reset.
module tb_mmio_uart_ctrl;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst, s_mmio, rd, wr;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rx_drv, loop_en;
  logic       rx_line, tx, irq;

  int total = 0;
  int bad   = 0;

  assign rx_line = loop_en ? tx : rx_drv;

  mmio_uart_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .s_mmio   (s_mmio),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rx       (rx_line),
    .tx       (tx),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    s_mmio = 1'b1; wr = 1'b1; addr = a; data_in = d;
    repeat (hold) @(negedge clk);
    wr = 1'b0; s_mmio = 1'b0;
    @(negedge clk);
  endtask

  task automatic readReg(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    s_mmio = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    d = data_out;
    @(negedge clk);
    rd = 1'b0; s_mmio = 1'b0;
    @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopv, input int stopLen);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_drv = stopv;
    repeat (stopLen) @(negedge clk);
    rx_drv = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic setDiv3();
    applyStimulus(3'd3, 8'h03, 1);
    applyStimulus(3'd4, 8'h00, 1);
    repeat (200) @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    logic [9:0] expLine;
    logic [9:0] frameBits;
    int fallAt, lowAfter, riseAt;

    rst = 1'b1; s_mmio = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = 3'd0; data_in = 8'd0; rx_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_irq", irq, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_data_out", data_out, 8'h00);
    readReg(3'd1, v); checkOutput("rst_status", v, 8'h05);
    readReg(3'd2, v); checkOutput("rst_ctrl", v, 8'h00);
    readReg(3'd3, v); checkOutput("rst_div_lo", v, 8'hA1);
    readReg(3'd4, v); checkOutput("rst_div_hi", v, 8'h00);

    // TX frame of 0x55 with a 5-cycle write strobe; samples taken mid-bit
    setDiv3();
    expLine  = {1'b1, 8'h55, 1'b0};
    fallAt   = -1;
    lowAfter = 0;
    @(negedge clk);
    s_mmio = 1'b1; wr = 1'b1; addr = 3'd0; data_in = 8'h55;
    for (int n = 1; n <= 1400; n++) begin
      @(negedge clk);
      if (n == 5) begin wr = 1'b0; s_mmio = 1'b0; end
      if (fallAt < 0 && tx == 1'b0) fallAt = n;
      if (fallAt >= 0 && n - fallAt >= 32 && (n - fallAt - 32) % BIT == 0 &&
          (n - fallAt - 32) / BIT < 10)
        checkOutput($sformatf("tx_bit%0d", (n - fallAt - 32) / BIT), tx,
                    expLine[(n - fallAt - 32) / BIT]);
      if (fallAt >= 0 && n - fallAt >= 645 && tx == 1'b0) lowAfter++;
    end
    checkOutput("tx_start_seen", (fallAt >= 0), 1'b1);
    checkOutput("tx_one_frame", lowAfter, 0);
    readReg(3'd1, v); checkOutput("tx_done_status", v, 8'h05);

    loop_en = 1'b1;
    for (int i = 1; i <= 16; i++) applyStimulus(3'd0, 8'(i), 1);
    repeat (16 * 10 * BIT + 400) @(negedge clk);
    readReg(3'd1, v); checkOutput("loop_status_full", v, 8'h06);
    for (int i = 1; i <= 16; i++) begin
      readReg(3'd0, v);
      checkOutput($sformatf("loop_rd%0d", i), v, 8'(i));
    end
    readReg(3'd0, v); checkOutput("loop_rd_empty", v, 8'h00);
    readReg(3'd1, v); checkOutput("loop_status_empty", v, 8'h05);
    loop_en = 1'b0;

    // One byte leaves the FIFO for the shifter, so the 18th write overflows
    doReset();
    applyStimulus(3'd3, 8'hFF, 1);
    applyStimulus(3'd4, 8'hFF, 1);
    for (int i = 0; i < 17; i++) applyStimulus(3'd0, 8'(8'h40 + i), 1);
    readReg(3'd1, v); checkOutput("txf_full_no_ovf", v, 8'h09);
    applyStimulus(3'd0, 8'h99, 1);
    readReg(3'd1, v); checkOutput("txf_ovf", v, 8'h89);
    applyStimulus(3'd1, 8'hE0, 1);
    readReg(3'd1, v); checkOutput("txf_w1c", v, 8'h09);

    doReset();
    setDiv3();
    for (int i = 0; i < 17; i++) sendFrame(8'(8'h20 + i), 1'b1, BIT);
    readReg(3'd1, v); checkOutput("rx_ovr_status", v, 8'h26);
    for (int i = 0; i < 16; i++) begin
      readReg(3'd0, v);
      checkOutput($sformatf("rx_ovr_rd%0d", i), v, 8'(8'h20 + i));
    end
    readReg(3'd1, v); checkOutput("rx_ovr_drained", v, 8'h25);
    applyStimulus(3'd1, 8'hE0, 1);
    readReg(3'd1, v); checkOutput("rx_ovr_w1c", v, 8'h05);

    // Stop bit released after 48 clk so the receiver's re-arm sees a high line
    sendFrame(8'h3C, 1'b0, 48);
    repeat (100) @(negedge clk);
    readReg(3'd1, v); checkOutput("fe_status", v, 8'h45);
    applyStimulus(3'd1, 8'hE0, 1);
    readReg(3'd1, v); checkOutput("fe_w1c", v, 8'h05);

    @(negedge clk);
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (150) @(negedge clk);
    readReg(3'd1, v); checkOutput("glitch_status", v, 8'h05);

    applyStimulus(3'd2, 8'h01, 1);
    checkOutput("irq_idle", irq, 1'b0);
    frameBits = {1'b1, 8'hA5, 1'b0};
    riseAt = -1;
    @(negedge clk);
    for (int c = 0; c < 10 * BIT; c++) begin
      rx_drv = frameBits[c / BIT];
      @(negedge clk);
      if (riseAt < 0 && irq == 1'b1) riseAt = c;
    end
    rx_drv = 1'b1;
    checkOutput("irq_rise_in_stop", (riseAt >= 590 && riseAt <= 630), 1'b1);
    readReg(3'd0, v); checkOutput("irq_data", v, 8'hA5);
    checkOutput("irq_held_until_pop", irq, 1'b1);
    @(negedge clk);
    checkOutput("irq_dropped", irq, 1'b0);
    applyStimulus(3'd2, 8'h00, 1);

    applyStimulus(3'd0, 8'h00, 1);
    applyStimulus(3'd0, 8'h00, 1);
    repeat (200) @(negedge clk);
    checkOutput("tx_mid_frame", tx, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1; s_mmio = 1'b1; rd = 1'b1; addr = 3'd1;
    #1;
    checkOutput("async_rst_tx", tx, 1'b1);
    checkOutput("async_rst_status", data_out, 8'h05);
    rd = 1'b0; s_mmio = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
